// File: rtl/jellyvl_etherneco_frame_tx_if.sv
// ---------------------------------------------------------------------------
// jellyvl_etherneco_frame_tx_if
//   First/last delimited payload byte stream feeding the Ethernet TX framer.
//   Signals:
//     first  - first payload byte of a frame
//     last   - last payload byte of a frame
//     data   - payload byte
//     valid  - byte valid
//     ready  - byte accepted when valid && ready
//   Modports:
//     master - stream source (the EtherNeco packet TX)
//     slave  - stream sink (the framer)
// ---------------------------------------------------------------------------
interface jellyvl_etherneco_frame_tx_if;
   logic       first;
   logic       last;
   logic [7:0] data;
   logic       valid;
   logic       ready;

   modport master (output first, last, data, valid, input ready);
   modport slave  (input first, last, data, valid, output ready);
endinterface

// File: rtl/jellyvl_etherneco_frame_tx.sv
// ---------------------------------------------------------------------------
// jellyvl_etherneco_frame_tx
//   Ethernet MAC-level TX framer. Wraps each first/last delimited byte stream
//   into a wire frame: preamble, SFD, payload, optional zero pad, CRC32 FCS
//   and inter-frame gap, driving a GMII-style 8-bit transmit interface.
//   Ports:
//     clk        - byte clock
//     reset      - synchronous, active-high
//     s          - payload stream (slave modport)
//     m_tx_data  - GMII TXD (registered)
//     m_tx_en    - GMII TX_EN (registered)
//     m_tx_er    - GMII TX_ER (registered)
//     busy       - high in every state except IDLE
//     underrun   - one-cycle pulse when the payload stream starved mid-frame
//     drop       - one-cycle pulse when a stray byte is discarded in IDLE
// ---------------------------------------------------------------------------
module jellyvl_etherneco_frame_tx #(
   parameter int unsigned PREAMBLE_LEN = 7,
   parameter int unsigned MIN_PAYLOAD  = 46,
   parameter int unsigned IFG_LEN      = 12
) (
   input  logic                         clk,
   input  logic                         reset,
   jellyvl_etherneco_frame_tx_if.slave  s,
   output logic [7:0]                   m_tx_data,
   output logic                         m_tx_en,
   output logic                         m_tx_er,
   output logic                         busy,
   output logic                         underrun,
   output logic                         drop
);

   typedef enum logic [2:0] {
      StIdle,
      StPre,
      StSfd,
      StPayload,
      StPad,
      StFcs,
      StIfg,
      StDrain
   } state_t;

   localparam logic [15:0] PreLast = 16'(PREAMBLE_LEN - 1);
   localparam logic [15:0] IfgLast = 16'(IFG_LEN - 1);
   localparam logic [15:0] MinPay  = 16'(MIN_PAYLOAD);

   state_t      state_q;
   logic [31:0] crc_q;
   logic [15:0] byteCnt_q;
   logic [15:0] phaseCnt_q;
   logic [7:0]  txData_q;
   logic        txEn_q;
   logic        txEr_q;
   logic        underrun_q;
   logic        drop_q;

   logic [15:0] byteCntInc;
   logic [31:0] fcsWord;
   logic [7:0]  fcsByte;

   // Reflected CRC32 (poly 0xEDB88320), one byte folded in LSB first.
   function automatic logic [31:0] crcByte(input logic [31:0] crc, input logic [7:0] b);
      logic [31:0] c;
      c = crc ^ {24'h000000, b};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return c;
   endfunction

   // Payload byte counter saturates so very long frames never wrap back
   // below the pad threshold. The FCS goes out LSB byte first, selected by
   // the low bits of the phase counter while in the FCS state.
   always_comb begin
      byteCntInc = (byteCnt_q == 16'hFFFF) ? byteCnt_q : byteCnt_q + 16'd1;
      fcsWord    = ~crc_q;
      fcsByte    = fcsWord[{phaseCnt_q[1:0], 3'b000} +: 8];
   end

   // Ready is only offered where a byte is actually taken: stray non-first
   // bytes in IDLE (to discard them), every PAYLOAD cycle, and DRAIN. The
   // opening byte of a frame is held in IDLE until the preamble is out.
   always_comb begin
      s.ready = 1'b0;
      case (state_q)
         StIdle:             s.ready = s.valid && !s.first;
         StPayload, StDrain: s.ready = 1'b1;
         default:            s.ready = 1'b0;
      endcase
   end

   // Framer state machine. Every wire output is registered here, so what the
   // current state decides at a clock edge appears on the wire for the
   // following cycle; outputs default to idle each cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         crc_q      <= 32'hFFFFFFFF;
         byteCnt_q  <= 16'd0;
         phaseCnt_q <= 16'd0;
         txData_q   <= 8'h00;
         txEn_q     <= 1'b0;
         txEr_q     <= 1'b0;
         underrun_q <= 1'b0;
         drop_q     <= 1'b0;
      end else begin
         txData_q   <= 8'h00;
         txEn_q     <= 1'b0;
         txEr_q     <= 1'b0;
         underrun_q <= 1'b0;
         drop_q     <= 1'b0;
         case (state_q)
            StIdle: begin
               if (s.valid && s.first) begin
                  txEn_q     <= 1'b1;
                  txData_q   <= 8'h55;
                  phaseCnt_q <= 16'd1;
                  state_q    <= (PREAMBLE_LEN <= 1) ? StSfd : StPre;
               end else if (s.valid) begin
                  drop_q <= 1'b1;
               end
            end
            StPre: begin
               txEn_q     <= 1'b1;
               txData_q   <= 8'h55;
               phaseCnt_q <= phaseCnt_q + 16'd1;
               if (phaseCnt_q >= PreLast) begin
                  state_q <= StSfd;
               end
            end
            StSfd: begin
               txEn_q    <= 1'b1;
               txData_q  <= 8'hD5;
               crc_q     <= 32'hFFFFFFFF;
               byteCnt_q <= 16'd0;
               state_q   <= StPayload;
            end
            StPayload: begin
               if (s.valid) begin
                  txEn_q    <= 1'b1;
                  txData_q  <= s.data;
                  crc_q     <= crcByte(crc_q, s.data);
                  byteCnt_q <= byteCntInc;
                  if (s.last) begin
                     phaseCnt_q <= 16'd0;
                     state_q    <= (byteCntInc < MinPay) ? StPad : StFcs;
                  end
               end else begin
                  txEn_q     <= 1'b1;
                  txEr_q     <= 1'b1;
                  underrun_q <= 1'b1;
                  state_q    <= StDrain;
               end
            end
            StPad: begin
               txEn_q    <= 1'b1;
               crc_q     <= crcByte(crc_q, 8'h00);
               byteCnt_q <= byteCntInc;
               if (byteCntInc >= MinPay) begin
                  phaseCnt_q <= 16'd0;
                  state_q    <= StFcs;
               end
            end
            StFcs: begin
               txEn_q     <= 1'b1;
               txData_q   <= fcsByte;
               phaseCnt_q <= phaseCnt_q + 16'd1;
               if (phaseCnt_q[1:0] == 2'd3) begin
                  phaseCnt_q <= 16'd0;
                  state_q    <= StIfg;
               end
            end
            StIfg: begin
               if (phaseCnt_q >= IfgLast) begin
                  state_q <= StIdle;
               end else begin
                  phaseCnt_q <= phaseCnt_q + 16'd1;
               end
            end
            StDrain: begin
               if (s.valid && s.last) begin
                  phaseCnt_q <= 16'd0;
                  state_q    <= StIfg;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign m_tx_data = txData_q;
   assign m_tx_en   = txEn_q;
   assign m_tx_er   = txEr_q;
   assign underrun  = underrun_q;
   assign drop      = drop_q;
   assign busy      = (state_q != StIdle);

endmodule
